// File: rtl/ofm_writeback.sv
// Output-feature-map writeback: quantizes systolic-array rows and writes them to output memory.
// Optional build macro OFM_RELU_EN clamps negative accumulators to zero before quantization.
module ofm_writeback #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int ACC_WIDTH     = 32,
  parameter int DATA_WIDTH    = 16,
  parameter int SHIFT         = 8,
  parameter int NO_TILE       = 64,
  parameter int NO_GROUP      = 1,
  parameter int ADDR_WIDTH    = 16,
  parameter int GROUP_STRIDE  = 1024
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                write_out_en,
  input  logic [SYSTOLIC_SIZE*ACC_WIDTH-1:0]  data_in,
  output logic                                mem_we,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] mem_wdata,
  output logic                                busy,
  output logic                                wb_done
);

  localparam int BW = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
  localparam int TW = (NO_TILE > 1) ? $clog2(NO_TILE) : 1;
  localparam int GW = (NO_GROUP > 1) ? $clog2(NO_GROUP) : 1;
  localparam logic [BW-1:0] BEAT_MAX  = BW'(SYSTOLIC_SIZE - 1);
  localparam logic [TW-1:0] TILE_MAX  = TW'(NO_TILE - 1);
  localparam logic [GW-1:0] GROUP_MAX = GW'(NO_GROUP - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

  state_t                              state, state_nx;
  logic [BW-1:0]                       beat_cnt;
  logic [TW-1:0]                       tile_cnt;
  logic [GW-1:0]                       group_cnt;
  logic                                stage1_valid;
  logic [ADDR_WIDTH-1:0]               stage1_addr;
  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] stage1_data;
  logic                                accept;
  logic                                last_beat;
  logic [ADDR_WIDTH-1:0]               beat_addr;
  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] quant;

  function automatic logic [DATA_WIDTH-1:0] quantize(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] v;
    v = acc;
`ifdef OFM_RELU_EN
    if (acc[ACC_WIDTH-1]) begin
      v = '0;
    end else begin
      v = acc;
    end
`endif
    v = v >>> SHIFT;
    if (v > SAT_MAX) begin
      v = SAT_MAX;
    end else if (v < SAT_MIN) begin
      v = SAT_MIN;
    end else begin
      v = v;
    end
    return v[DATA_WIDTH-1:0];
  endfunction

  // Beat acceptance, terminal-beat detection and row address of the current beat
  always_comb begin
    accept    = (state == ACTIVE) && write_out_en && !start;
    last_beat = accept && (beat_cnt == BEAT_MAX) && (tile_cnt == TILE_MAX) &&
                (group_cnt == GROUP_MAX);
    beat_addr = ADDR_WIDTH'(group_cnt) * ADDR_WIDTH'(GROUP_STRIDE) +
                ADDR_WIDTH'(tile_cnt) * ADDR_WIDTH'(SYSTOLIC_SIZE) + ADDR_WIDTH'(beat_cnt);
  end

  // Per-lane quantization of the incoming row
  always_comb begin
    quant = '0;
    for (int k = 0; k < SYSTOLIC_SIZE; k++) begin
      quant[k*DATA_WIDTH +: DATA_WIDTH] = quantize(data_in[k*ACC_WIDTH +: ACC_WIDTH]);
    end
  end

  // Next-state logic; start restarts a run from any busy state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ACTIVE : IDLE;
      ACTIVE:  begin
        if (start) begin
          state_nx = ACTIVE;
        end else if (last_beat) begin
          state_nx = FLUSH;
        end else begin
          state_nx = ACTIVE;
        end
      end
      FLUSH:   begin
        if (start) begin
          state_nx = ACTIVE;
        end else if (!stage1_valid) begin
          state_nx = DONE;
        end else begin
          state_nx = FLUSH;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register with registered status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      wb_done <= 1'b0;
    end else begin
      state   <= state_nx;
      busy    <= (state_nx == ACTIVE) || (state_nx == FLUSH);
      wb_done <= (state_nx == DONE);
    end
  end

  // Beat/tile/group counters, cleared by start
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      beat_cnt  <= '0;
      tile_cnt  <= '0;
      group_cnt <= '0;
    end else if (accept) begin
      if (beat_cnt == BEAT_MAX) begin
        beat_cnt <= '0;
        if (tile_cnt == TILE_MAX) begin
          tile_cnt  <= '0;
          group_cnt <= (group_cnt == GROUP_MAX) ? '0 : group_cnt + GW'(1);
        end else begin
          tile_cnt <= tile_cnt + TW'(1);
        end
      end else begin
        beat_cnt <= beat_cnt + BW'(1);
      end
    end
  end

  // Two-stage write pipeline; start discards whatever is in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage1_valid <= 1'b0;
      stage1_addr  <= '0;
      stage1_data  <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      stage1_valid <= accept;
      if (accept) begin
        stage1_addr <= beat_addr;
        stage1_data <= quant;
      end
      mem_we <= stage1_valid && !start;
      if (stage1_valid && !start) begin
        mem_addr  <= stage1_addr;
        mem_wdata <= stage1_data;
      end
    end
  end

endmodule

// File: tb/tb_ofm_writeback.sv
// Self-checking bench for ofm_writeback: random rows against a run-level reference model.
module tb_ofm_writeback;
  localparam int S = 16, AW = 32, DW = 16, SH = 8, NT = 2, NG = 2, GS = 1024, ADW = 16;
  localparam int TOTAL = S * NT * NG;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic write_out_en = 1'b0;
  logic [S*AW-1:0] data_in = '0;
  logic mem_we;
  logic [ADW-1:0] mem_addr;
  logic [S*DW-1:0] mem_wdata;
  logic busy, wb_done;

  always #5 clk = ~clk;

  ofm_writeback #(.SYSTOLIC_SIZE(S), .ACC_WIDTH(AW), .DATA_WIDTH(DW), .SHIFT(SH),
    .NO_TILE(NT), .NO_GROUP(NG), .ADDR_WIDTH(ADW), .GROUP_STRIDE(GS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .write_out_en(write_out_en), .data_in(data_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .wb_done(wb_done));

  typedef struct {
    int              due;
    logic [ADW-1:0]  addr;
    logic [S*DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int edge_no = 0, n_checks = 0, n_fail = 0;
  int m_n = 0, done_due = -1, writes_seen = 0, done_seen = 0;
  bit m_active = 1'b0, m_busy = 1'b0;
  logic [ADW-1:0] last_addr = '0;
  logic [S*DW-1:0] last_data = '0;

  // Reference quantizer: floor-divide by 2^SH then clip to the signed output range
  function automatic logic [DW-1:0] ref_q(input logic [AW-1:0] raw);
    longint v, hi, lo;
    v  = longint'($signed(raw));
    hi = (64'sd1 <<< (DW - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
`ifdef OFM_RELU_EN
    if (v < 0) v = 0;
`endif
    v = v >>> SH;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return v[DW-1:0];
  endfunction

  function automatic logic [AW-1:0] rand_acc();
    logic [AW-1:0] v;
    case ($urandom_range(0, 3))
      0: v = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      1: v = $urandom;
      2: v = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: begin
        v = 32'(32767 * 256 + $urandom_range(0, 511)) - 32'd256;
        if ($urandom_range(0, 1) == 1) v = -v;
      end
    endcase
    return v;
  endfunction

  function automatic logic [S*AW-1:0] rand_row();
    logic [S*AW-1:0] r;
    for (int k = 0; k < S; k++) r[k*AW +: AW] = rand_acc();
    return r;
  endfunction

  // One clock: drive inputs, advance the model, then compare every output after the edge
  task automatic cyc(input bit st, input bit en, input logic [S*AW-1:0] d, input bit rst);
    int e;
    int n;
    wr_t w;
    e = edge_no + 1;
    start = st; write_out_en = en; data_in = d; rst_n = !rst;
    if (rst) begin
      exp_q.delete(); m_active = 0; m_busy = 0; m_n = 0; done_due = -1;
      last_addr = '0; last_data = '0;
    end else if (st) begin
      while (exp_q.size() > 0 && exp_q[$].due >= e) void'(exp_q.pop_back());
      m_active = 1; m_busy = 1; m_n = 0; done_due = -1;
    end else if (en && m_active) begin
      n = m_n;
      w.due  = e + 1;
      w.addr = ADW'((n / (S * NT)) * GS + ((n / S) % NT) * S + (n % S));
      for (int k = 0; k < S; k++) w.data[k*DW +: DW] = ref_q(d[k*AW +: AW]);
      exp_q.push_back(w);
      m_n++;
      if (m_n == TOTAL) begin
        m_active = 0;
        done_due = e + 2;
      end
    end
    @(posedge clk);
    edge_no = e;
    #1;
    if (e == done_due) m_busy = 0;
    if (mem_we === 1'b1) writes_seen++;
    if (wb_done === 1'b1) done_seen++;
    n_checks++;
    if (exp_q.size() > 0 && exp_q[0].due == e) begin
      w = exp_q.pop_front();
      last_addr = w.addr; last_data = w.data;
      if (mem_we !== 1'b1) begin
        n_fail++; $display("FAIL mem_we edge %0d: got %b expected 1", e, mem_we);
      end
    end else if (mem_we !== 1'b0) begin
      n_fail++; $display("FAIL mem_we edge %0d: got %b expected 0", e, mem_we);
    end
    n_checks++;
    if (mem_addr !== last_addr) begin
      n_fail++; $display("FAIL mem_addr edge %0d: got %h expected %h", e, mem_addr, last_addr);
    end
    n_checks++;
    if (mem_wdata !== last_data) begin
      n_fail++; $display("FAIL mem_wdata edge %0d: got %h expected %h", e, mem_wdata, last_data);
    end
    n_checks++;
    if (busy !== m_busy) begin
      n_fail++; $display("FAIL busy edge %0d: got %b expected %b", e, busy, m_busy);
    end
    n_checks++;
    if (wb_done !== (e == done_due)) begin
      n_fail++; $display("FAIL wb_done edge %0d: got %b expected %b", e, wb_done, e == done_due);
    end
  endtask

  task automatic test_reset();
    cyc(0, 1, rand_row(), 1);
    cyc(1, 1, rand_row(), 1);
    n_checks++;
    if ({mem_we, busy, wb_done} !== 3'b000 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b busy=%b done=%b addr=%h expected all zero",
               mem_we, busy, wb_done, mem_addr);
    end
  endtask

  task automatic test_basic_run();
    logic [S*AW-1:0] d;
    d = '0;
    d[AW-1:0] = 32'h0000_0300;
    cyc(1, 0, '0, 0);
    writes_seen = 0; done_seen = 0;
    for (int i = 0; i < S; i++) cyc(0, 1, d, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    n_checks++;
    if (mem_addr !== 16'd15 || mem_wdata[DW-1:0] !== 16'h0003 || writes_seen != S) begin
      n_fail++;
      $display("FAIL basic_run: got addr=%0d lane0=%h writes=%0d expected 15 0003 %0d",
               mem_addr, mem_wdata[DW-1:0], writes_seen, S);
    end
  endtask

  task automatic test_saturation_complete();
    logic [S*AW-1:0] d;
    logic [DW-1:0] neg_exp;
    int guard;
`ifdef OFM_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'h8000;
`endif
    d = rand_row();
    d[AW-1:0]    = 32'h7FFF_FFFF;
    d[2*AW-1:AW] = 32'h8000_0000;
    cyc(0, 1, d, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    n_checks++;
    if (mem_wdata[DW-1:0] !== 16'h7FFF || mem_wdata[2*DW-1:DW] !== neg_exp) begin
      n_fail++;
      $display("FAIL saturation: got lane0=%h lane1=%h expected 7fff %h",
               mem_wdata[DW-1:0], mem_wdata[2*DW-1:DW], neg_exp);
    end
    guard = 0;
    while (m_n < TOTAL && guard < 1000) begin
      cyc(0, $urandom_range(0, 3) != 0, rand_row(), 0);
      guard++;
    end
    for (int i = 0; i < 6; i++) cyc(0, 1, rand_row(), 0);
    n_checks++;
    if (writes_seen != TOTAL || done_seen != 1 || mem_addr !== ADW'(GS + S * NT - 1)) begin
      n_fail++;
      $display("FAIL full_run: got writes=%0d done=%0d last_addr=%0d expected %0d 1 %0d",
               writes_seen, done_seen, mem_addr, TOTAL, GS + S * NT - 1);
    end
  endtask

  task automatic test_idle_en();
    for (int i = 0; i < 4; i++) cyc(0, 1, rand_row(), 0);
    cyc(1, 1, rand_row(), 0);
    cyc(0, 1, rand_row(), 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    n_checks++;
    if (mem_addr !== 16'd0) begin
      n_fail++; $display("FAIL start_with_en: got first addr %0d expected 0", mem_addr);
    end
  endtask

  task automatic test_restart();
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, rand_row(), 0);
    cyc(1, 0, '0, 0);
    writes_seen = 0;
    for (int i = 0; i < 3; i++) cyc(0, 1, rand_row(), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0);
    n_checks++;
    if (writes_seen != 3 || mem_addr !== 16'd2) begin
      n_fail++;
      $display("FAIL restart: got writes=%0d addr=%0d expected 3 2", writes_seen, mem_addr);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cyc(0, 1, rand_row(), 0);
    cyc(0, 1, rand_row(), 1);
    writes_seen = 0;
    cyc(0, 1, rand_row(), 0);
    cyc(0, 1, rand_row(), 0);
    n_checks++;
    if (writes_seen != 0 || busy !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got writes=%0d busy=%b addr=%h expected 0 0 0",
               writes_seen, busy, mem_addr);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, '0, 0);
    writes_seen = 0; done_seen = 0;
    for (int i = 0; i < TOTAL; i++) cyc(0, 1, rand_row(), 0);
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 0);
    n_checks++;
    if (writes_seen != TOTAL - 1 || done_seen != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_abort: got writes=%0d done=%0d busy=%b expected %0d 0 1",
               writes_seen, done_seen, busy, TOTAL - 1);
    end
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_saturation_complete();
    test_idle_en();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
